// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the fetch/data memory arbiter
//
// Purpose: response FSM state encoding and the fetch starvation threshold,
//          imported by mem_arbiter and mem_arb_fair.
// Ports:   none (package).

package mem_arbiter_pkg;

  // Response-phase state: which requester owns the SRAM read data this cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSP_IF = 2'd1,
    RSP_DM = 2'd2
  } arb_state_e;

  // Number of denied fetch cycles after which fetch wins the next conflict.
  localparam logic [1:0] STARVE_THRESH = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between pipeline stages, arbiter and shared SRAM
//
// Purpose: groups the fetch port, data port, SRAM command/response and stall.
// Ports:   if_*  fetch request/grant/response
//          dm_*  data request/grant/response
//          mem_* single-port SRAM command and read data
//          stall pipeline stall
// Modports: slave  - the arbiter
//           master - the environment (pipeline + SRAM)

interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_w_en;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_valid;
  logic [31:0] dm_rdata;

  logic        mem_cs;
  logic [31:0] mem_addr;
  logic [3:0]  mem_w_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        stall;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_addr, dm_w_en, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_valid, if_rdata,
    output dm_gnt, dm_valid, dm_rdata,
    output mem_cs, mem_addr, mem_w_en, mem_wdata,
    output stall
  );

  modport master (
    output if_req, if_addr, if_flush,
    output dm_req, dm_addr, dm_w_en, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_valid, if_rdata,
    input  dm_gnt, dm_valid, dm_rdata,
    input  mem_cs, mem_addr, mem_w_en, mem_wdata,
    input  stall
  );
endinterface

// File: rtl/mem_arb_fair.sv
// rtl/mem_arb_fair.sv - fetch starvation counter for the memory arbiter
//
// Purpose: counts cycles in which a pending fetch is denied and raises
//          if_prio once the count reaches STARVE_THRESH.
// Ports:   clk, rst  clock, async active-high reset
//          if_req    fetch request pending
//          if_gnt    fetch granted this cycle
//          if_prio   fetch wins the next conflict

module mem_arb_fair
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic if_prio
);

  logic [1:0] cnt;

  // Any fetch grant relieves starvation; saturate so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
    end else if (if_gnt) begin
      cnt <= 2'd0;
    end else if (if_req && cnt != 2'd3) begin
      cnt <= cnt + 2'd1;
    end
  end

  assign if_prio = (cnt >= STARVE_THRESH);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a shared single-port SRAM
//
// Purpose: grants one of fetch/data per cycle (data has priority), drives the
//          winner's command onto the SRAM and routes the read data back one
//          cycle later. Build option MEM_ARB_FAIR_EN adds fetch anti-starvation.
// Ports:   clk  clock
//          rst  async active-high reset
//          bus  mem_arbiter_if.slave (fetch port, data port, SRAM, stall)

module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  arb_state_e state;
  logic       if_drop;
  logic       if_prio;
  logic       if_win;
  logic       dm_win;
  logic       if_ok;
  logic       dm_ok;

`ifdef MEM_ARB_FAIR_EN
  mem_arb_fair u_fair (
    .clk     (clk),
    .rst     (rst),
    .if_req  (bus.if_req),
    .if_gnt  (if_win),
    .if_prio (if_prio)
  );
`else
  assign if_prio = 1'b0;
`endif

  // Data wins conflicts unless a starved fetch has earned priority.
  assign dm_win = bus.dm_req & ~(bus.if_req & if_prio);
  assign if_win = bus.if_req & ~dm_win;

  always_comb begin
    bus.if_gnt    = if_win;
    bus.dm_gnt    = dm_win;
    bus.mem_cs    = if_win | dm_win;
    bus.mem_addr  = '0;
    bus.mem_w_en  = '0;
    bus.mem_wdata = '0;
    if (dm_win) begin
      bus.mem_addr  = bus.dm_addr;
      bus.mem_w_en  = bus.dm_w_en;
      bus.mem_wdata = bus.dm_wdata;
    end else if (if_win) begin
      bus.mem_addr  = bus.if_addr;
    end
    bus.stall = (bus.if_req & ~if_win) | (bus.dm_req & ~dm_win);
  end

  // State names the owner of next cycle's SRAM data. if_drop remembers a
  // flush seen in the fetch grant cycle so that response is swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      if_drop <= 1'b0;
    end else begin
      if_drop <= 1'b0;
      if (dm_win) begin
        state <= RSP_DM;
      end else if (if_win) begin
        state   <= RSP_IF;
        if_drop <= bus.if_flush;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign if_ok = (state == RSP_IF) & ~if_drop & ~bus.if_flush;
  assign dm_ok = (state == RSP_DM);

  assign bus.if_valid = if_ok;
  assign bus.if_rdata = if_ok ? bus.mem_rdata : '0;
  assign bus.dm_valid = dm_ok;
  assign bus.dm_rdata = dm_ok ? bus.mem_rdata : '0;

endmodule
